// File: rtl/fetch_queue.sv
// Two-wide instruction fetch queue: circular buffer of DEPTH entries between fetch and decode.
// Optional full-stall statistics counter when FETCH_QUEUE_STAT_EN is defined.
module fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_i_flush,
  input  logic        io_i_fetch_pack_valid,
  input  logic        io_i_fetch_pack_bits_valids_0,
  input  logic        io_i_fetch_pack_bits_valids_1,
  input  logic [63:0] io_i_fetch_pack_bits_pc,
  input  logic [31:0] io_i_fetch_pack_bits_insts_0,
  input  logic [31:0] io_i_fetch_pack_bits_insts_1,
  input  logic        io_i_fetch_pack_bits_branch_predict_pack_valid,
  input  logic        io_i_fetch_pack_bits_branch_predict_pack_taken,
  input  logic [63:0] io_i_fetch_pack_bits_branch_predict_pack_target,
  output logic        io_o_fetch_pack_ready,
  output logic        io_o_dec_valid_0,
  output logic        io_o_dec_valid_1,
  output logic [63:0] io_o_dec_pc_0,
  output logic [63:0] io_o_dec_pc_1,
  output logic [31:0] io_o_dec_inst_0,
  output logic [31:0] io_o_dec_inst_1,
  output logic        io_o_dec_bp_valid_0,
  output logic        io_o_dec_bp_valid_1,
  output logic        io_o_dec_bp_taken_0,
  output logic        io_o_dec_bp_taken_1,
  output logic [63:0] io_o_dec_bp_target_0,
  output logic [63:0] io_o_dec_bp_target_1,
  input  logic        io_i_dec_ready
`ifdef FETCH_QUEUE_STAT_EN
  ,
  output logic [31:0] io_o_full_stall_cnt
`endif
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0] r_head, r_tail;
  logic [PW-1:0] w_count;
  logic          w_ready;
  logic          w_enq, w_both;
  logic [1:0]    w_enq_n, w_deq_n;
  logic [IW-1:0] w_hidx0, w_hidx1, w_tidx0, w_tidx1;

  logic [63:0] r_pc     [DEPTH];
  logic [31:0] r_inst   [DEPTH];
  logic        r_bp_v   [DEPTH];
  logic        r_bp_t   [DEPTH];
  logic [63:0] r_bp_tgt [DEPTH];

  logic [63:0] w_a_pc, w_b_pc;
  logic [31:0] w_a_inst;
  logic        w_a_bp_v, w_a_bp_t;
  logic [63:0] w_a_bp_tgt;

  assign w_count = r_tail - r_head;
  assign w_ready = (w_count <= PW'(DEPTH - 2));
  assign io_o_fetch_pack_ready = w_ready;

  assign w_hidx0 = r_head[IW-1:0];
  assign w_hidx1 = w_hidx0 + 1'b1;
  assign w_tidx0 = r_tail[IW-1:0];
  assign w_tidx1 = w_tidx0 + 1'b1;

  assign io_o_dec_valid_0 = (w_count != '0) & ~io_i_flush;
  assign io_o_dec_valid_1 = (w_count >= PW'(2)) & ~io_i_flush;

  assign w_enq   = io_i_fetch_pack_valid & w_ready & ~io_i_flush;
  assign w_both  = io_i_fetch_pack_bits_valids_0 & io_i_fetch_pack_bits_valids_1;
  assign w_enq_n = w_enq ? ({1'b0, io_i_fetch_pack_bits_valids_0} +
                            {1'b0, io_i_fetch_pack_bits_valids_1}) : 2'd0;
  assign w_deq_n = (io_i_dec_ready & ~io_i_flush) ?
                   ({1'b0, io_o_dec_valid_0} + {1'b0, io_o_dec_valid_1}) : 2'd0;

  // Entry at tail: either slot 0 of a full pack, or the lone valid slot (which is also the youngest).
  assign w_b_pc     = io_i_fetch_pack_bits_pc + 64'd4;
  assign w_a_pc     = io_i_fetch_pack_bits_valids_0 ? io_i_fetch_pack_bits_pc : w_b_pc;
  assign w_a_inst   = io_i_fetch_pack_bits_valids_0 ? io_i_fetch_pack_bits_insts_0
                                                    : io_i_fetch_pack_bits_insts_1;
  assign w_a_bp_v   = w_both ? 1'b0 : io_i_fetch_pack_bits_branch_predict_pack_valid;
  assign w_a_bp_t   = w_both ? 1'b0 : io_i_fetch_pack_bits_branch_predict_pack_taken;
  assign w_a_bp_tgt = w_both ? '0 : io_i_fetch_pack_bits_branch_predict_pack_target;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (io_i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + {{(PW-2){1'b0}}, w_deq_n};
      r_tail <= r_tail + {{(PW-2){1'b0}}, w_enq_n};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]     <= '0;
        r_inst[i]   <= '0;
        r_bp_v[i]   <= 1'b0;
        r_bp_t[i]   <= 1'b0;
        r_bp_tgt[i] <= '0;
      end
    end else if (w_enq && (w_enq_n != 2'd0)) begin
      r_pc[w_tidx0]     <= w_a_pc;
      r_inst[w_tidx0]   <= w_a_inst;
      r_bp_v[w_tidx0]   <= w_a_bp_v;
      r_bp_t[w_tidx0]   <= w_a_bp_t;
      r_bp_tgt[w_tidx0] <= w_a_bp_tgt;
      if (w_both) begin
        r_pc[w_tidx1]     <= w_b_pc;
        r_inst[w_tidx1]   <= io_i_fetch_pack_bits_insts_1;
        r_bp_v[w_tidx1]   <= io_i_fetch_pack_bits_branch_predict_pack_valid;
        r_bp_t[w_tidx1]   <= io_i_fetch_pack_bits_branch_predict_pack_taken;
        r_bp_tgt[w_tidx1] <= io_i_fetch_pack_bits_branch_predict_pack_target;
      end
    end
  end

  assign io_o_dec_pc_0        = r_pc[w_hidx0];
  assign io_o_dec_pc_1        = r_pc[w_hidx1];
  assign io_o_dec_inst_0      = r_inst[w_hidx0];
  assign io_o_dec_inst_1      = r_inst[w_hidx1];
  assign io_o_dec_bp_valid_0  = r_bp_v[w_hidx0];
  assign io_o_dec_bp_valid_1  = r_bp_v[w_hidx1];
  assign io_o_dec_bp_taken_0  = r_bp_t[w_hidx0];
  assign io_o_dec_bp_taken_1  = r_bp_t[w_hidx1];
  assign io_o_dec_bp_target_0 = r_bp_tgt[w_hidx0];
  assign io_o_dec_bp_target_1 = r_bp_tgt[w_hidx1];

`ifdef FETCH_QUEUE_STAT_EN
  logic [31:0] r_stall_cnt;

  // Flush does not clear the statistic; only reset does.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (io_i_fetch_pack_valid && !w_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign io_o_full_stall_cnt = r_stall_cnt;
`endif

endmodule
